rob_commit: RTL and testbench

ROB_COMMIT -- requirements
Module: rob_commit

---
 rtl/rob_commit_if.sv | 33 +++
 rtl/rob_commit.sv | 155 +++++++++++++++
 tb/tb_rob_commit.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_commit_if.sv
// Allocation, completion and retire bundle between the decode/execute side and the reorder buffer.
// The master drives allocation and completion; the slave is the ROB itself.
interface rob_commit_if #(
  parameter int ALLOC_W  = 4,
  parameter int COMMIT_W = 3,
  parameter int CMPLT_W  = 4,
  parameter int IDX_W    = 5
);
  logic [ALLOC_W-1:0]          alloc_valid;
  logic                        alloc_ready;
  logic [ALLOC_W*IDX_W-1:0]    rob_entries;
  logic [ALLOC_W*2*IDX_W-1:0]  alloc_old_aliases;
  logic [ALLOC_W*8-1:0]        alloc_arch_regs;
  logic [CMPLT_W-1:0]          cmplt_valid;
  logic [CMPLT_W*IDX_W-1:0]    cmplt_rob_idx;
  logic [COMMIT_W-1:0]         commit_valid;
  logic [COMMIT_W*2*IDX_W-1:0] commit_free_regs;
  logic [COMMIT_W*8-1:0]       commit_arch_regs;
  logic [IDX_W:0]              rob_count;
  logic                        rob_empty;

  modport master (
    output alloc_valid, alloc_old_aliases, alloc_arch_regs, cmplt_valid, cmplt_rob_idx,
    input  alloc_ready, rob_entries, commit_valid, commit_free_regs, commit_arch_regs,
           rob_count, rob_empty
  );

  modport slave (
    input  alloc_valid, alloc_old_aliases, alloc_arch_regs, cmplt_valid, cmplt_rob_idx,
    output alloc_ready, rob_entries, commit_valid, commit_free_regs, commit_arch_regs,
           rob_count, rob_empty
  );
endinterface

// File: rtl/rob_commit.sv
// Reorder buffer with in-order retirement: allocates up to ALLOC_W entries per cycle,
// marks completions, and retires up to COMMIT_W done entries per cycle with registered outputs.
module rob_commit #(
  parameter int DEPTH    = 32,
  parameter int ALLOC_W  = 4,
  parameter int COMMIT_W = 3
) (
  input logic         clk,
  input logic         rst,
  rob_commit_if.slave rob
);
  localparam int IDX_W   = $clog2(DEPTH);
  localparam int CNT_W   = IDX_W + 1;
  localparam int CMPLT_W = 4;
  localparam int ACC_W   = $clog2(ALLOC_W + 1);
  localparam int RET_W   = $clog2(COMMIT_W + 1);
  localparam int AL_W    = 2 * IDX_W;
  localparam int AR_W    = 8;

  typedef logic [IDX_W-1:0] idx_t;

  idx_t                     head_q, head_d;
  idx_t                     tail_q, tail_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [DEPTH-1:0]         done_q, done_d;
  logic [AL_W-1:0]          alias_q [DEPTH];
  logic [AL_W-1:0]          alias_d [DEPTH];
  logic [AR_W-1:0]          arch_q  [DEPTH];
  logic [AR_W-1:0]          arch_d  [DEPTH];
  logic [COMMIT_W-1:0]      commit_valid_q, commit_valid_d;
  logic [COMMIT_W*AL_W-1:0] commit_free_q, commit_free_d;
  logic [COMMIT_W*AR_W-1:0] commit_arch_q, commit_arch_d;

  logic                     alloc_ready;
  logic                     acc_run;
  logic [ALLOC_W-1:0]       acc_mask;
  logic [ACC_W-1:0]         acc_cnt;
  logic                     ret_run;
  logic [COMMIT_W-1:0]      ret_mask;
  logic [RET_W-1:0]         ret_cnt;
  logic [ALLOC_W*IDX_W-1:0] entries;

  // Depends on registered occupancy only, so the decoder never sees a loop through alloc_valid.
  assign alloc_ready = (count_q <= CNT_W'(DEPTH - ALLOC_W));

  assign rob.alloc_ready      = alloc_ready;
  assign rob.rob_entries      = entries;
  assign rob.rob_count        = count_q;
  assign rob.rob_empty        = (count_q == '0);
  assign rob.commit_valid     = commit_valid_q;
  assign rob.commit_free_regs = commit_free_q;
  assign rob.commit_arch_regs = commit_arch_q;

  always_comb begin : entry_idx
    entries = '0;
    for (int i = 0; i < ALLOC_W; i++) begin
      entries[IDX_W*i +: IDX_W] = tail_q + idx_t'(i);
    end
  end

  // Accepted slots are the unbroken run of requests starting at slot 0.
  always_comb begin : accept
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    acc_run  = alloc_ready;
    acc_mask = '0;
    acc_cnt  = '0;
    for (int i = 0; i < ALLOC_W; i++) begin
      acc_run     = acc_run & rob.alloc_valid[i];
      acc_mask[i] = acc_run;
      if (acc_run) acc_cnt = acc_cnt + ACC_W'(1);
    end
  end

  // Retire the oldest run of valid+done entries, judged on pre-edge state.
  always_comb begin : retire
    ret_run  = 1'b1;
    ret_mask = '0;
    ret_cnt  = '0;
    for (int m = 0; m < COMMIT_W; m++) begin
      ret_run     = ret_run & valid_q[head_q + idx_t'(m)] & done_q[head_q + idx_t'(m)];
      ret_mask[m] = ret_run;
      if (ret_run) ret_cnt = ret_cnt + RET_W'(1);
    end
  end

  always_comb begin : next_state
    valid_d        = valid_q;
    done_d         = done_q;
    alias_d        = alias_q;
    arch_d         = arch_q;
    commit_valid_d = '0;
    commit_free_d  = '0;
    commit_arch_d  = '0;

    for (int j = 0; j < CMPLT_W; j++) begin
      if (rob.cmplt_valid[j] && valid_q[rob.cmplt_rob_idx[IDX_W*j +: IDX_W]]) begin
        done_d[rob.cmplt_rob_idx[IDX_W*j +: IDX_W]] = 1'b1;
      end
    end

    for (int m = 0; m < COMMIT_W; m++) begin
      if (ret_mask[m]) begin
        valid_d[head_q + idx_t'(m)]         = 1'b0;
        done_d[head_q + idx_t'(m)]          = 1'b0;
        commit_valid_d[m]                   = 1'b1;
        commit_free_d[AL_W*m +: AL_W]       = alias_q[head_q + idx_t'(m)];
        commit_arch_d[AR_W*m +: AR_W]       = arch_q[head_q + idx_t'(m)];
      end
    end

    // Allocation targets free slots only, so it never collides with the retiring entries above.
    for (int i = 0; i < ALLOC_W; i++) begin
      if (acc_mask[i]) begin
        valid_d[tail_q + idx_t'(i)] = 1'b1;
        done_d[tail_q + idx_t'(i)]  = 1'b0;
        alias_d[tail_q + idx_t'(i)] = rob.alloc_old_aliases[AL_W*i +: AL_W];
        arch_d[tail_q + idx_t'(i)]  = rob.alloc_arch_regs[AR_W*i +: AR_W];
      end
    end

    head_d  = head_q + idx_t'(ret_cnt);
    tail_d  = tail_q + idx_t'(acc_cnt);
    count_d = count_q + CNT_W'(acc_cnt) - CNT_W'(ret_cnt);
  end

  // NOTE: sequential state uses non-blocking assignments; blocking is reserved for always_comb.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      valid_q        <= '0;
      done_q         <= '0;
      commit_valid_q <= '0;
      commit_free_q  <= '0;
      commit_arch_q  <= '0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      valid_q        <= valid_d;
      done_q         <= done_d;
      commit_valid_q <= commit_valid_d;
      commit_free_q  <= commit_free_d;
      commit_arch_q  <= commit_arch_d;
    end
  end

  // NOTE: payload storage is not reset; it is only ever read behind a set valid bit.
  always_ff @(posedge clk) begin
    alias_q <= alias_d;
    arch_q  <= arch_d;
  end
endmodule

// File: tb/tb_rob_commit.sv
// Self-checking bench for rob_commit: directed scenarios with literal expectations,
// then randomized traffic checked against a queue-based model of the reorder buffer.
module tb_rob_commit;
  logic clk;
  logic rst;

  rob_commit_if bus ();

  rob_commit dut (
    .clk (clk),
    .rst (rst),
    .rob (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  typedef struct {
    int         idx;
    bit         done;
    logic [9:0] al;
    logic [7:0] ar;
  } ent_t;

  ent_t        mq[$];
  int          m_tail;
  logic [2:0]  exp_cv;
  logic [29:0] exp_fr;
  logic [23:0] exp_ar;

  function automatic logic [19:0] exp_entries(int t);
    logic [19:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[5*i +: 5] = 5'((t + i) % 32);
    return r;
  endfunction

  function automatic logic [9:0] alias_of(int e);
    return 10'((e * 37 + 5) % 1024);
  endfunction

  function automatic logic [7:0] arch_of(int e);
    return 8'((e * 11 + 3) % 256);
  endfunction

  task automatic drive(input logic [3:0] av, input logic [39:0] al, input logic [31:0] ar,
                       input logic [3:0] cv, input logic [19:0] ci);
    bus.alloc_valid       = av;
    bus.alloc_old_aliases = al;
    bus.alloc_arch_regs   = ar;
    bus.cmplt_valid       = cv;
    bus.cmplt_rob_idx     = ci;
  endtask

  // One clock edge; the model follows the ROB rules, then outputs settle for sampling at +1.
  task automatic cycle();
    int   n;
    int   acc;
    bit   ready;
    bit   run;
    ent_t e;
    @(posedge clk);
    ready  = (32 - mq.size()) >= 4;
    exp_cv = '0;
    exp_fr = '0;
    exp_ar = '0;
    if (rst) begin
      mq.delete();
      m_tail = 0;
    end else begin
      n = 0;
      while (n < 3 && n < mq.size() && mq[n].done) begin
        exp_cv[n]          = 1'b1;
        exp_fr[10*n +: 10] = mq[n].al;
        exp_ar[8*n +: 8]   = mq[n].ar;
        n++;
      end
      for (int j = 0; j < 4; j++) begin
        if (bus.cmplt_valid[j]) begin
          for (int k = 0; k < mq.size(); k++) begin
            if (mq[k].idx == int'(bus.cmplt_rob_idx[5*j +: 5])) begin
              e = mq[k];
              e.done = 1'b1;
              mq[k] = e;
            end
          end
        end
      end
      repeat (n) void'(mq.pop_front());
      if (ready) begin
        run = 1'b1;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
          run = run & bus.alloc_valid[i];
          if (run) begin
            e.idx  = (m_tail + i) % 32;
            e.done = 1'b0;
            e.al   = bus.alloc_old_aliases[10*i +: 10];
            e.ar   = bus.alloc_arch_regs[8*i +: 8];
            mq.push_back(e);
            acc++;
          end
        end
        m_tail = (m_tail + acc) % 32;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    drive('0, '0, '0, '0, '0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.alloc_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.alloc_ready); end
    total++; if (bus.rob_entries !== {5'd3, 5'd2, 5'd1, 5'd0}) begin bad++; $display("FAIL reset_entries got=%h want=%h", bus.rob_entries, {5'd3, 5'd2, 5'd1, 5'd0}); end
    total++; if (bus.rob_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", bus.rob_empty); end
    total++; if (bus.rob_count !== 6'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.rob_count); end
    total++; if (bus.commit_valid !== 3'b000 || bus.commit_free_regs !== '0 || bus.commit_arch_regs !== '0) begin
      bad++; $display("FAIL reset_commit got=%b/%h/%h want=0", bus.commit_valid, bus.commit_free_regs, bus.commit_arch_regs);
    end
  endtask

  task automatic test_group_commit();
    do_reset();
    drive(4'b1111, {5'd10, 5'd11, 5'd8, 5'd9, 5'd6, 5'd7, 5'd4, 5'd5}, 32'h87654321, '0, '0);
    cycle();
    total++; if (bus.rob_count !== 6'd4) begin bad++; $display("FAIL grp_count4 got=%0d want=4", bus.rob_count); end
    total++; if (bus.rob_entries !== {5'd7, 5'd6, 5'd5, 5'd4}) begin bad++; $display("FAIL grp_entries got=%h", bus.rob_entries); end
    drive('0, '0, '0, 4'b0111, {5'd0, 5'd2, 5'd1, 5'd0});
    cycle();
    total++; if (bus.commit_valid !== 3'b000) begin bad++; $display("FAIL grp_early got=%b want=000", bus.commit_valid); end
    drive('0, '0, '0, '0, '0);
    cycle();
    total++; if (bus.commit_valid !== 3'b111) begin bad++; $display("FAIL grp_valid got=%b want=111", bus.commit_valid); end
    total++; if (bus.commit_free_regs !== {5'd8, 5'd9, 5'd6, 5'd7, 5'd4, 5'd5}) begin bad++; $display("FAIL grp_free got=%h", bus.commit_free_regs); end
    total++; if (bus.commit_arch_regs !== 24'h654321) begin bad++; $display("FAIL grp_arch got=%h want=654321", bus.commit_arch_regs); end
    total++; if (bus.rob_count !== 6'd1) begin bad++; $display("FAIL grp_count1 got=%0d want=1", bus.rob_count); end
    drive('0, '0, '0, 4'b0001, {15'd0, 5'd3});
    cycle();
    total++; if (bus.commit_valid !== 3'b000) begin bad++; $display("FAIL grp_pulse got=%b want=000", bus.commit_valid); end
    drive('0, '0, '0, '0, '0);
    cycle();
    total++; if (bus.commit_valid !== 3'b001 || bus.commit_free_regs !== {20'd0, 5'd10, 5'd11}) begin
      bad++; $display("FAIL grp_last got=%b/%h", bus.commit_valid, bus.commit_free_regs);
    end
    total++; if (bus.rob_empty !== 1'b1) begin bad++; $display("FAIL grp_empty got=%b want=1", bus.rob_empty); end
  endtask

  task automatic test_in_order();
    do_reset();
    drive(4'b1111, 40'h12345_6789a, 32'hdeadbeef, '0, '0);
    cycle();
    drive('0, '0, '0, 4'b0011, {10'd0, 5'd2, 5'd1});
    cycle();
    drive('0, '0, '0, '0, '0);
    cycle();
    total++; if (bus.commit_valid !== 3'b000) begin bad++; $display("FAIL order_blocked1 got=%b want=000", bus.commit_valid); end
    cycle();
    total++; if (bus.commit_valid !== 3'b000) begin bad++; $display("FAIL order_blocked2 got=%b want=000", bus.commit_valid); end
    drive('0, '0, '0, 4'b0001, '0);
    cycle();
    drive('0, '0, '0, '0, '0);
    cycle();
    total++; if (bus.commit_valid !== 3'b111) begin bad++; $display("FAIL order_release got=%b want=111", bus.commit_valid); end
    total++; if (bus.rob_count !== 6'd1) begin bad++; $display("FAIL order_count got=%0d want=1", bus.rob_count); end
  endtask

  task automatic test_full();
    do_reset();
    for (int g = 0; g < 8; g++) begin
      drive(4'b1111, {$urandom, $urandom}, $urandom, '0, '0);
      cycle();
      if (g == 6) begin
        total++; if (bus.rob_count !== 6'd28 || bus.alloc_ready !== 1'b1) begin
          bad++; $display("FAIL full_28 count=%0d ready=%b want 28/1", bus.rob_count, bus.alloc_ready);
        end
      end
    end
    total++; if (bus.rob_count !== 6'd32) begin bad++; $display("FAIL full_count got=%0d want=32", bus.rob_count); end
    total++; if (bus.alloc_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", bus.alloc_ready); end
    drive(4'b1111, {$urandom, $urandom}, $urandom, '0, '0);
    cycle();
    total++; if (bus.rob_count !== 6'd32 || bus.rob_entries !== {5'd3, 5'd2, 5'd1, 5'd0}) begin
      bad++; $display("FAIL full_ignore count=%0d entries=%h", bus.rob_count, bus.rob_entries);
    end
  endtask

  task automatic test_wrap();
    logic [39:0] al;
    logic [31:0] ar;
    do_reset();
    for (int k = 0; k < 15; k++) begin
      al = '0; ar = '0;
      for (int i = 0; i < 2; i++) begin
        al[10*i +: 10] = alias_of(2*k + i);
        ar[8*i +: 8]   = arch_of(2*k + i);
      end
      if (k > 0) drive(4'b0011, al, ar, 4'b0011, {10'd0, 5'(2*k - 1), 5'(2*k - 2)});
      else       drive(4'b0011, al, ar, 4'b0000, '0);
      cycle();
      total++; if (bus.commit_valid !== exp_cv || bus.commit_free_regs !== exp_fr) begin
        bad++; $display("FAIL wrap_steady k=%0d got=%b/%h want=%b/%h", k, bus.commit_valid, bus.commit_free_regs, exp_cv, exp_fr);
      end
    end
    total++; if (bus.rob_entries !== {5'd1, 5'd0, 5'd31, 5'd30}) begin bad++; $display("FAIL wrap_entries got=%h", bus.rob_entries); end
    al = '0; ar = '0;
    for (int i = 0; i < 3; i++) begin
      al[10*i +: 10] = alias_of((30 + i) % 32);
      ar[8*i +: 8]   = arch_of((30 + i) % 32);
    end
    drive(4'b0111, al, ar, 4'b0011, {10'd0, 5'd29, 5'd28});
    cycle();
    drive('0, '0, '0, 4'b0111, {5'd0, 5'd0, 5'd31, 5'd30});
    cycle();
    total++; if (bus.commit_valid !== 3'b011) begin bad++; $display("FAIL wrap_pre got=%b want=011", bus.commit_valid); end
    drive('0, '0, '0, '0, '0);
    cycle();
    total++; if (bus.commit_valid !== 3'b111 || bus.commit_free_regs !== {alias_of(0), alias_of(31), alias_of(30)}) begin
      bad++; $display("FAIL wrap_retire got=%b/%h want=111/%h", bus.commit_valid, bus.commit_free_regs, {alias_of(0), alias_of(31), alias_of(30)});
    end
    total++; if (bus.commit_arch_regs !== {arch_of(0), arch_of(31), arch_of(30)}) begin bad++; $display("FAIL wrap_arch got=%h", bus.commit_arch_regs); end
    total++; if (bus.rob_count !== 6'd0 || bus.rob_entries !== {5'd4, 5'd3, 5'd2, 5'd1}) begin
      bad++; $display("FAIL wrap_after count=%0d entries=%h", bus.rob_count, bus.rob_entries);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    drive(4'b1111, {$urandom, $urandom}, $urandom, '0, '0);
    cycle();
    drive(4'b1111, {$urandom, $urandom}, $urandom, '0, '0);
    cycle();
    drive(4'b0011, {$urandom, $urandom}, $urandom, 4'b0011, {10'd0, 5'd7, 5'd5});
    cycle();
    drive('0, '0, '0, '0, '0);
    cycle();
    total++; if (bus.rob_count !== 6'd10 || bus.commit_valid !== 3'b000) begin
      bad++; $display("FAIL mid_inflight count=%0d cv=%b want 10/000", bus.rob_count, bus.commit_valid);
    end
    drive(4'b1111, {$urandom, $urandom}, $urandom, 4'b0001, {15'd0, 5'd0});
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    drive('0, '0, '0, '0, '0);
    total++; if (bus.commit_valid !== 3'b000 || bus.rob_count !== 6'd0 || bus.alloc_ready !== 1'b1) begin
      bad++; $display("FAIL mid_reset cv=%b count=%0d ready=%b", bus.commit_valid, bus.rob_count, bus.alloc_ready);
    end
    for (int c = 0; c < 3; c++) begin
      cycle();
      total++; if (bus.commit_valid !== 3'b000 || bus.commit_free_regs !== '0) begin
        bad++; $display("FAIL mid_nofree c=%0d cv=%b free=%h", c, bus.commit_valid, bus.commit_free_regs);
      end
    end
  endtask

  task automatic test_sparse_alloc();
    do_reset();
    drive('0, '0, '0, 4'b0001, {15'd0, 5'd0});
    cycle();
    drive(4'b0101, {10'd0, 10'd77, 10'd0, 10'd33}, 32'h00aa_0055, '0, '0);
    cycle();
    total++; if (bus.rob_count !== 6'd1 || bus.rob_entries !== {5'd4, 5'd3, 5'd2, 5'd1}) begin
      bad++; $display("FAIL sparse_tail count=%0d entries=%h want 1/tail=1", bus.rob_count, bus.rob_entries);
    end
    drive('0, '0, '0, '0, '0);
    cycle();
    cycle();
    total++; if (bus.commit_valid !== 3'b000) begin bad++; $display("FAIL sparse_stale_done got=%b want=000", bus.commit_valid); end
    drive(4'b1011, {$urandom, $urandom}, $urandom, 4'b0001, {15'd0, 5'd0});
    cycle();
    total++; if (bus.rob_count !== 6'd3) begin bad++; $display("FAIL sparse_1011 got=%0d want=3", bus.rob_count); end
    drive('0, '0, '0, '0, '0);
    cycle();
    total++; if (bus.commit_valid !== 3'b001 || bus.commit_free_regs !== {20'd0, 10'd33} || bus.commit_arch_regs !== {16'd0, 8'h55}) begin
      bad++; $display("FAIL sparse_commit got=%b/%h/%h", bus.commit_valid, bus.commit_free_regs, bus.commit_arch_regs);
    end
  endtask

  task automatic test_random();
    logic [3:0]  cv;
    logic [19:0] ci;
    int          r;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      cv = '0;
      ci = '0;
      for (int j = 0; j < 4; j++) begin
        if ($urandom_range(0, 2) != 0) begin
          if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
            r = mq[$urandom_range(0, mq.size() - 1)].idx;
            cv[j] = 1'b1;
          end else begin
            r = $urandom_range(0, 31);
            cv[j] = (((r - m_tail + 32) % 32) >= 4);
          end
          ci[5*j +: 5] = 5'(r);
        end
      end
      if (c % 100 > 80) cv = '0;
      drive(4'($urandom), {$urandom, $urandom}, $urandom, cv, ci);
      cycle();
      total++; if (bus.commit_valid !== exp_cv || bus.commit_free_regs !== exp_fr || bus.commit_arch_regs !== exp_ar) begin
        bad++; $display("FAIL rand_commit c=%0d got=%b/%h/%h want=%b/%h/%h", c, bus.commit_valid, bus.commit_free_regs,
                        bus.commit_arch_regs, exp_cv, exp_fr, exp_ar);
      end
      total++; if (bus.rob_count !== 6'(mq.size()) || bus.rob_empty !== (mq.size() == 0) ||
                   bus.alloc_ready !== ((32 - mq.size()) >= 4) || bus.rob_entries !== exp_entries(m_tail)) begin
        bad++; $display("FAIL rand_state c=%0d count=%0d/%0d empty=%b ready=%b entries=%h/%h", c, bus.rob_count, mq.size(),
                        bus.rob_empty, bus.alloc_ready, bus.rob_entries, exp_entries(m_tail));
      end
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    m_tail = 0;
    rst    = 1'b1;
    drive('0, '0, '0, '0, '0);
    test_reset();
    test_group_commit();
    test_in_order();
    test_full();
    test_wrap();
    test_reset_midflight();
    test_sparse_alloc();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
